// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W            = 32;
    localparam int unsigned CNT_W             = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage: synchronous write, asynchronous read, contents start at zero.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    // Not touched by reset: contents survive a reset of the responder.
    logic [WORD_W-1:0] mem_q [DEPTH_WORDS] = '{default: '0};

    // Commit one word on the clock edge when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Target side of the core's data-memory port: one word per req/ready
// handshake, a fixed number of wait states, address range/alignment check.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for req; captures addr/we/wdata on accept
// S_WAIT | counting down wait states; req is not looked at
// S_RESP | ready high for this one cycle; always returns to S_IDLE
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [WORD_W-1:0] wdata,
    output logic              ready,
    output logic [WORD_W-1:0] rdata,
    output logic              err,
    output logic              busy
);

    localparam int unsigned      AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0]      SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : '0;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hold_addr_q, hold_addr_d;
    logic               hold_we_q, hold_we_d;
    logic [WORD_W-1:0]  hold_wdata_q, hold_wdata_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [WORD_W-1:0]  rdata_q, rdata_d;

    logic [31:0]        offset_w;
    logic [AW-1:0]      word_idx;
    logic               bad;
    logic               mem_we;
    logic [WORD_W-1:0]  mem_rdata;

    // The check uses the next-cycle holding values so a zero-wait access
    // is judged on the address being captured on that same edge.
    assign offset_w = hold_addr_d - BASE_ADDR;
    assign word_idx = offset_w[AW+1:2];
    assign bad      = (hold_addr_d[1:0] != 2'b00)
                    || (hold_addr_d < BASE_ADDR)
                    || ({1'b0, offset_w} >= SPAN);

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk_in),
        .we_i    (mem_we),
        .addr_i  (word_idx),
        .wdata_i (hold_wdata_d),
        .rdata_o (mem_rdata)
    );

    // Next-state, capture and response-entry decisions.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_addr_d  = hold_addr_q;
        hold_we_d    = hold_we_q;
        hold_wdata_d = hold_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    hold_addr_d  = addr;
                    hold_we_d    = we;
                    hold_wdata_d = wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // RESP is never held, so state_d == S_RESP marks the entry edge.
        ready_d = (state_d == S_RESP);
        busy_d  = (state_d != S_IDLE);
        err_d   = err_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        if (state_d == S_RESP) begin
            err_d = bad;
            if (bad) begin
                rdata_d = '0;
            end else if (hold_we_d) begin
                mem_we = 1'b1;
            end else begin
                rdata_d = mem_rdata;
            end
        end
    end

    // State, counter, holding and output registers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            hold_addr_q  <= '0;
            hold_we_q    <= 1'b0;
            hold_wdata_q <= '0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_addr_q  <= hold_addr_d;
            hold_we_q    <= hold_we_d;
            hold_wdata_q <= hold_wdata_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            rdata_q      <= rdata_d;
        end
    end

    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance,
// a transaction-level reference model, and directed literal checks.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic        ready_s [2];
    logic [31:0] rdata_s [2];
    logic        err_s   [2];
    logic        busy_s  [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .BASE_ADDR(BASE)) u_w2 (
        .clk_in(clk), .reset(rst), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .ready(ready_s[0]), .rdata(rdata_s[0]), .err(err_s[0]),
        .busy(busy_s[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_w0 (
        .clk_in(clk), .reset(rst), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .ready(ready_s[1]), .rdata(rdata_s[1]), .err(err_s[1]),
        .busy(busy_s[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int unsigned cyc = 0;
    bit          m_pend  [2];
    int unsigned m_t0    [2];
    bit          m_ready [2];
    bit          m_busy  [2];
    bit          m_err   [2];
    logic [31:0] m_rdata [2];
    bit          m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wd    [2];
    logic [31:0] m_mem   [2][DEPTH];

    function automatic int unsigned wk(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic model_step();
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pend[k]  = 0;
                m_ready[k] = 0;
                m_busy[k]  = 0;
                m_err[k]   = 0;
                m_rdata[k] = '0;
            end else begin
                m_ready[k] = 0;
                if (m_pend[k] && cyc == m_t0[k] + wk(k) + 1) begin
                    m_pend[k] = 0;
                    m_busy[k] = 0;
                end else if (!m_pend[k] && req_s[k]) begin
                    m_pend[k] = 1;
                    m_t0[k]   = cyc;
                    m_busy[k] = 1;
                    m_we[k]   = we_s[k];
                    m_addr[k] = addr_s[k];
                    m_wd[k]   = wdata_s[k];
                end
                if (m_pend[k] && cyc == m_t0[k] + wk(k)) begin
                    longint off;
                    bit     bad;
                    int     idx;
                    off = longint'(m_addr[k]) - longint'(BASE);
                    bad = (m_addr[k][1:0] != 2'b00) || (off < 0) || (off >= 4 * DEPTH);
                    m_ready[k] = 1;
                    m_err[k]   = bad;
                    if (bad) begin
                        m_rdata[k] = '0;
                    end else begin
                        idx = int'(off / 4);
                        if (m_we[k]) m_mem[k][idx] = m_wd[k];
                        else         m_rdata[k]    = m_mem[k][idx];
                    end
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_t0[k] = 0; m_ready[k] = 0; m_busy[k] = 0;
            m_err[k] = 0; m_rdata[k] = '0; m_we[k] = 0; m_addr[k] = '0; m_wd[k] = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m_ready%0d@%0d", k, cyc), ready_s[k], m_ready[k]);
                chk($sformatf("m_busy%0d@%0d", k, cyc), busy_s[k], m_busy[k]);
                chk($sformatf("m_rdata%0d@%0d", k, cyc), rdata_s[k], m_rdata[k]);
                if (m_ready[k]) chk($sformatf("m_err%0d@%0d", k, cyc), err_s[k], m_err[k]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Starts just after a negedge with the DUT idle; returns one cycle
    // after the ready pulse so the DUT is back in IDLE.
    task automatic do_txn(input int k, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int hold,
                          output int lat, output logic [31:0] rd, output logic e);
        req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d;
        lat = 0;
        @(posedge clk);
        do begin
            @(negedge clk);
            lat++;
            if (lat >= hold) req_s[k] = 1'b0;
        end while (!ready_s[k] && lat < 20);
        rd = rdata_s[k];
        e  = err_s[k];
        req_s[k] = 1'b0;
        @(negedge clk);
    endtask

    // Two loads with req held high; measures ready spacing and busy-low gap.
    task automatic b2b(input int k, input logic [31:0] a,
                       output int sp, output int bl, output logic [31:0] rd);
        int i  = 0;
        int n  = 0;
        int c1 = 0;
        sp = 0; bl = 0; rd = '0;
        req_s[k] = 1'b1; we_s[k] = 1'b0; addr_s[k] = a;
        while (n < 2 && i < 40) begin
            @(negedge clk);
            i++;
            if (ready_s[k]) begin
                n++;
                if (n == 1) begin
                    c1 = i;
                    rd = rdata_s[k];
                end else begin
                    sp = i - c1;
                    req_s[k] = 1'b0;
                end
            end else if (n == 1 && !busy_s[k]) begin
                bl++;
            end
        end
        req_s[k] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        int          sp;
        int          bl;
        int          n;
        logic [31:0] rd;
        logic        e;

        for (int k = 0; k < 2; k++) begin
            req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0;
        end

        @(negedge clk);
        chk("rst_ready", ready_s[0], 0);
        chk("rst_err",   err_s[0],   0);
        chk("rst_rdata", rdata_s[0], 0);
        chk("rst_busy",  busy_s[0],  0);
        chk("rst_busy_w0", busy_s[1], 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_busy",  busy_s[0],  0);
        chk("idle_ready", ready_s[0], 0);

        do_txn(0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 1, lat, rd, e);
        chk("st_lat", lat, 3);
        chk("st_err", e, 0);
        do_txn(0, 1'b0, 32'h1001_0008, 32'h0, 1, lat, rd, e);
        chk("ld_lat", lat, 3);
        chk("ld_rdata", rd, 32'hDEAD_BEEF);
        chk("ld_err", e, 0);

        do_txn(0, 1'b0, 32'h1001_0002, 32'h0, 1, lat, rd, e);
        chk("mis_err", e, 1);
        chk("mis_rdata", rd, 0);
        do_txn(0, 1'b1, 32'h1001_1000, 32'hCAFE_F00D, 1, lat, rd, e);
        chk("oor_err", e, 1);
        chk("oor_rdata", rd, 0);
        do_txn(0, 1'b0, 32'h1000_FFFC, 32'h0, 1, lat, rd, e);
        chk("below_err", e, 1);
        do_txn(0, 1'b0, 32'h1001_0FFC, 32'h0, 1, lat, rd, e);
        chk("last_err", e, 0);
        chk("last_rdata", rd, 0);
        do_txn(0, 1'b1, 32'h1001_0FFC, 32'h600D_F00D, 1, lat, rd, e);
        chk("last_st_err", e, 0);

        b2b(0, 32'h1001_0008, sp, bl, rd);
        chk("b2b_space", sp, 4);
        chk("b2b_busylow", bl, 1);
        chk("b2b_rdata", rd, 32'hDEAD_BEEF);

        do_txn(0, 1'b0, 32'h1001_0FFC, 32'h0, 2, lat, rd, e);
        chk("drop_lat", lat, 3);
        chk("drop_rdata", rd, 32'h600D_F00D);

        do_txn(0, 1'b1, 32'h1001_0010, 32'h1122_3344, 1, lat, rd, e);
        chk("pre_st_err", e, 0);
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h1001_0010; wdata_s[0] = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        req_s[0] = 1'b0;
        chk("mid_busy", busy_s[0], 1);
        #2 rst = 1'b1;
        #1 chk("rst_mid_busy", busy_s[0], 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready_s[0]) n++;
        end
        chk("rst_no_ready", n, 0);
        do_txn(0, 1'b0, 32'h1001_0010, 32'h0, 1, lat, rd, e);
        chk("rst_kept", rd, 32'h1122_3344);

        do_txn(1, 1'b1, 32'h1001_0004, 32'h0BAD_C0DE, 1, lat, rd, e);
        chk("w0_st_lat", lat, 1);
        chk("w0_st_err", e, 0);
        do_txn(1, 1'b0, 32'h1001_0004, 32'h0, 1, lat, rd, e);
        chk("w0_ld_lat", lat, 1);
        chk("w0_ld_rdata", rd, 32'h0BAD_C0DE);
        do_txn(1, 1'b0, 32'h1001_0001, 32'h0, 1, lat, rd, e);
        chk("w0_mis_err", e, 1);
        b2b(1, 32'h1001_0004, sp, bl, rd);
        chk("w0_b2b_space", sp, 2);
        chk("w0_b2b_busylow", bl, 1);
        chk("w0_b2b_rdata", rd, 32'h0BAD_C0DE);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
